// File: rtl/trig_align_pkg.sv
// Shared constants, sync-state encoding and the slot-to-SURF mapping
// used by the SURF trigger alignment front end.
package trig_align_pkg;

    localparam int CYCLE_LEN_DEF   = 8;
    localparam int LOCK_CYCLES_DEF = 4;
    localparam int CNT_W           = 16;

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_SYNC   = 1'b1
    } sync_state_e;

    function automatic int real_index(input int t, input int s, input int real_per_tio);
        return t * real_per_tio + s;
    endfunction

endpackage

// File: rtl/trig_phase_tracker.sv
// Command-phase tracker: position counter, sync/lock/phase-error logic and
// the trigger-word strobe with its word index.
module trig_phase_tracker
    import trig_align_pkg::*;
#(
    parameter  int CYCLE_LEN       = CYCLE_LEN_DEF,
    parameter  int WORDS_PER_CYCLE = 2,
    parameter  int LOCK_CYCLES     = LOCK_CYCLES_DEF,
    localparam int PW              = $clog2(CYCLE_LEN),
    localparam int WW              = (WORDS_PER_CYCLE > 1) ? $clog2(WORDS_PER_CYCLE) : 1
) (
    input  logic          sysclk_i,
    input  logic          sysclk_rstn_i,
    input  logic          sysclk_phase_i,
    input  logic [PW-1:0] offset_i,
    output logic          strobe,
    output logic [WW-1:0] word,
    output logic          pos0,
    output logic          phase_err,
    output logic          locked,
    output sync_state_e   state
);

    localparam int STEP = CYCLE_LEN / WORDS_PER_CYCLE;
    localparam int SW   = $clog2(STEP);
    localparam int LW   = $clog2(LOCK_CYCLES + 1);
    localparam logic [PW-1:0] STEP_MASK = PW'(STEP - 1);

    logic [PW-1:0] pos_q;
    logic [PW-1:0] cur_pos;
    logic [PW-1:0] rel_pos;
    logic [LW-1:0] lock_cnt_q;
    logic [LW-1:0] lock_cnt_d;
    logic          sync_now;
    logic          good;
    sync_state_e   state_q;

    // pos_q is the predicted position; a phase pulse forces the current one to 0
    assign sync_now  = (state_q == ST_SYNC);
    assign cur_pos   = sysclk_phase_i ? '0 : pos_q;
    assign rel_pos   = cur_pos - offset_i;
    assign pos0      = (cur_pos == '0);
    assign phase_err = sync_now && (sysclk_phase_i ? (pos_q != '0) : (pos_q == '0));
    assign good      = sysclk_phase_i && !phase_err;
    assign strobe    = sync_now && ((rel_pos & STEP_MASK) == '0);
    assign word      = WW'(rel_pos >> SW);
    assign state     = state_q;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (phase_err) begin
            lock_cnt_d = '0;
        end else if (good && (lock_cnt_q < LW'(LOCK_CYCLES))) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) begin
            state_q    <= ST_UNSYNC;
            pos_q      <= '0;
            lock_cnt_q <= '0;
            locked     <= 1'b0;
        end else begin
            pos_q      <= cur_pos + 1'b1;
            lock_cnt_q <= lock_cnt_d;
            locked     <= (lock_cnt_d >= LW'(LOCK_CYCLES));
            case (state_q)
                ST_UNSYNC: if (sysclk_phase_i) state_q <= ST_SYNC;
                default:   state_q <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: rtl/trig_surf_align.sv
// SURF trigger-link front end: compacts populated slots, applies the
// cycle-aligned mask, registers strobed words and tracks misalignment.
module trig_surf_align
    import trig_align_pkg::*;
#(
    parameter  int NTIO            = 4,
    parameter  int SLOTS_PER_TIO   = 8,
    parameter  int REAL_PER_TIO    = 7,
    parameter  int DW              = 16,
    parameter  int CYCLE_LEN       = CYCLE_LEN_DEF,
    parameter  int WORDS_PER_CYCLE = 2,
    parameter  int LOCK_CYCLES     = LOCK_CYCLES_DEF,
    localparam int NREAL           = NTIO * REAL_PER_TIO,
    localparam int NSLOT           = NTIO * SLOTS_PER_TIO,
    localparam int PW              = $clog2(CYCLE_LEN),
    localparam int WW              = (WORDS_PER_CYCLE > 1) ? $clog2(WORDS_PER_CYCLE) : 1
) (
    input  logic                sysclk_i,
    input  logic                sysclk_rstn_i,
    input  logic                sysclk_phase_i,
    input  logic [PW-1:0]       offset_i,
    input  logic [NREAL-1:0]    mask_i,
    input  logic                mask_update_i,
    input  logic                err_clr_i,
    input  logic [NSLOT*DW-1:0] trig_dat_i,
    input  logic [NSLOT-1:0]    trig_dat_valid_i,
    output logic [NREAL*DW-1:0] trig_dat_o,
    output logic                trig_valid_o,
    output logic [WW-1:0]       trig_word_o,
    output logic                turf_trigger_ce_o,
    output logic                locked_o,
    output logic                phase_err_o,
    output logic [NREAL-1:0]    align_err_o,
    output logic [CNT_W-1:0]    align_err_count_o
);

    logic              strobe;
    logic              pos0;
    logic              phase_err_now;
    logic              sync;
    logic [WW-1:0]     word;
    sync_state_e       state;
    logic [NREAL-1:0]  shadow_q;
    logic [NREAL-1:0]  active_q;
    logic [NREAL-1:0]  eff_mask;
    logic [NREAL-1:0]  mis;
    logic [NREAL*DW-1:0] dat_masked;

    trig_phase_tracker #(
        .CYCLE_LEN       (CYCLE_LEN),
        .WORDS_PER_CYCLE (WORDS_PER_CYCLE),
        .LOCK_CYCLES     (LOCK_CYCLES)
    ) u_tracker (
        .sysclk_i       (sysclk_i),
        .sysclk_rstn_i  (sysclk_rstn_i),
        .sysclk_phase_i (sysclk_phase_i),
        .offset_i       (offset_i),
        .strobe         (strobe),
        .word           (word),
        .pos0           (pos0),
        .phase_err      (phase_err_now),
        .locked         (locked_o),
        .state          (state)
    );

    assign sync = (state == ST_SYNC);

    // The shadow mask only moves into use at position 0, so a cycle never sees a split mask
    assign eff_mask = pos0 ? (mask_update_i ? mask_i : shadow_q) : active_q;

    for (genvar t = 0; t < NTIO; t++) begin : g_tio
        for (genvar s = 0; s < SLOTS_PER_TIO; s++) begin : g_slot
            localparam int P = t * SLOTS_PER_TIO + s;
            if (s < REAL_PER_TIO) begin : g_real
                localparam int R = real_index(t, s, REAL_PER_TIO);
                assign dat_masked[R*DW +: DW] = eff_mask[R] ? '0 : trig_dat_i[P*DW +: DW];
                assign mis[R] = sync && !strobe && !eff_mask[R] && trig_dat_valid_i[P];
            end else begin : g_empty
                logic unused_slot;
                assign unused_slot = ^{trig_dat_i[P*DW +: DW], trig_dat_valid_i[P]};
            end
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) begin
            shadow_q          <= '1;
            active_q          <= '1;
            trig_dat_o        <= '0;
            trig_valid_o      <= 1'b0;
            trig_word_o       <= '0;
            turf_trigger_ce_o <= 1'b0;
            phase_err_o       <= 1'b0;
            align_err_o       <= '0;
            align_err_count_o <= '0;
        end else begin
            if (mask_update_i) shadow_q <= mask_i;
            active_q          <= eff_mask;
            trig_valid_o      <= strobe;
            turf_trigger_ce_o <= strobe;
            if (strobe) begin
                trig_dat_o  <= dat_masked;
                trig_word_o <= word;
            end
            // A fresh error in the clearing cycle survives the clear
            phase_err_o <= phase_err_now | (phase_err_o & ~err_clr_i);
            align_err_o <= mis | (align_err_o & {NREAL{~err_clr_i}});
            if (err_clr_i) begin
                align_err_count_o <= {{(CNT_W-1){1'b0}}, |mis};
            end else if ((|mis) && (align_err_count_o != '1)) begin
                align_err_count_o <= align_err_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trig_surf_align.sv
// Randomised self-checking bench for trig_surf_align against a cycle-level
// behavioural model built from position/mask/error rules.
module tb_trig_surf_align;

    localparam int NTIO = 4, SLOTS = 8, REALT = 7, DW = 16, CL = 8, WPC = 2, LOCK = 4;
    localparam int NREAL = NTIO * REALT, NSLOT = NTIO * SLOTS, STEP = CL / WPC;
    localparam int VW = 5 + NREAL + 16 + NREAL * DW;

    logic                sysclk_i = 1'b0;
    logic                sysclk_rstn_i = 1'b0;
    logic                sysclk_phase_i = 1'b0;
    logic [2:0]          offset_i = 3'd1;
    logic [NREAL-1:0]    mask_i = '0;
    logic                mask_update_i = 1'b0;
    logic                err_clr_i = 1'b0;
    logic [NSLOT*DW-1:0] trig_dat_i = '0;
    logic [NSLOT-1:0]    trig_dat_valid_i = '0;
    logic [NREAL*DW-1:0] trig_dat_o;
    logic                trig_valid_o;
    logic [0:0]          trig_word_o;
    logic                turf_trigger_ce_o;
    logic                locked_o;
    logic                phase_err_o;
    logic [NREAL-1:0]    align_err_o;
    logic [15:0]         align_err_count_o;

    int n_checks = 0;
    int n_pass   = 0;

    trig_surf_align dut (
        .sysclk_i          (sysclk_i),
        .sysclk_rstn_i     (sysclk_rstn_i),
        .sysclk_phase_i    (sysclk_phase_i),
        .offset_i          (offset_i),
        .mask_i            (mask_i),
        .mask_update_i     (mask_update_i),
        .err_clr_i         (err_clr_i),
        .trig_dat_i        (trig_dat_i),
        .trig_dat_valid_i  (trig_dat_valid_i),
        .trig_dat_o        (trig_dat_o),
        .trig_valid_o      (trig_valid_o),
        .trig_word_o       (trig_word_o),
        .turf_trigger_ce_o (turf_trigger_ce_o),
        .locked_o          (locked_o),
        .phase_err_o       (phase_err_o),
        .align_err_o       (align_err_o),
        .align_err_count_o (align_err_count_o)
    );

    // ---------------- clock ----------------
    always #5 sysclk_i = ~sysclk_i;

    // ---------------- reference model ----------------
    int               m_pos, m_lock, m_cnt, m_word;
    bit               m_sync, m_locked, m_perr, m_valid;
    bit [NREAL-1:0]   m_align, m_active, m_shadow;
    logic [NREAL*DW-1:0] m_dat;
    int               mm_cur, mm_rel;
    bit               mm_bad, mm_strobe;
    bit [NREAL-1:0]   mm_eff, mm_mis;

    always @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) begin
            m_pos = 0; m_lock = 0; m_cnt = 0; m_word = 0;
            m_sync = 0; m_locked = 0; m_perr = 0; m_valid = 0;
            m_align = '0; m_active = '1; m_shadow = '1; m_dat = '0;
        end else begin
            mm_cur    = sysclk_phase_i ? 0 : m_pos;
            mm_bad    = m_sync && (sysclk_phase_i ? (m_pos != 0) : (m_pos == 0));
            mm_eff    = (mm_cur == 0) ? (mask_update_i ? mask_i : m_shadow) : m_active;
            mm_rel    = (mm_cur - int'(offset_i) + CL) % CL;
            mm_strobe = m_sync && ((mm_rel % STEP) == 0);
            m_valid   = mm_strobe;
            if (mm_strobe) begin
                m_word = mm_rel / STEP;
                for (int t = 0; t < NTIO; t++)
                    for (int s = 0; s < REALT; s++)
                        m_dat[(t*REALT+s)*DW +: DW] = mm_eff[t*REALT+s] ? 16'h0 : trig_dat_i[(t*SLOTS+s)*DW +: DW];
            end
            for (int t = 0; t < NTIO; t++)
                for (int s = 0; s < REALT; s++)
                    mm_mis[t*REALT+s] = m_sync && !mm_strobe && !mm_eff[t*REALT+s] && trig_dat_valid_i[t*SLOTS+s];
            m_align = err_clr_i ? mm_mis : (m_align | mm_mis);
            if (err_clr_i) m_cnt = (mm_mis != 0) ? 1 : 0;
            else if (mm_mis != 0 && m_cnt < 65535) m_cnt = m_cnt + 1;
            m_perr = err_clr_i ? mm_bad : (m_perr | mm_bad);
            if (mm_bad) m_lock = 0;
            else if (sysclk_phase_i && m_lock < LOCK) m_lock = m_lock + 1;
            m_locked = (m_lock >= LOCK);
            if (mask_update_i) m_shadow = mask_i;
            m_active = mm_eff;
            if (sysclk_phase_i) m_sync = 1;
            m_pos = (mm_cur + 1) % CL;
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        return {m_valid, 1'(m_word), m_valid, m_locked, m_perr, m_align, 16'(m_cnt), m_dat};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {trig_valid_o, trig_word_o, turf_trigger_ce_o, locked_o, phase_err_o,
                align_err_o, align_err_count_o, trig_dat_o};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick(input bit ph);
        sysclk_phase_i = ph;
        @(posedge sysclk_i);
        #1;
        mask_update_i = 1'b0;
        err_clr_i     = 1'b0;
    endtask

    task automatic rand_data(input bit no_ffff);
        for (int i = 0; i < NSLOT; i++) begin
            trig_dat_i[i*DW +: DW] = 16'($urandom_range(0, 16'hFFFF));
            if (no_ffff && trig_dat_i[i*DW +: DW] == 16'hFFFF) trig_dat_i[i*DW +: DW] = 16'h0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sysclk_rstn_i = 1'b0;
        tick(0); tick(0);
        n_checks++;
        if (obs_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", obs_vec());
        else n_pass++;
        sysclk_rstn_i = 1'b1;
    endtask

    task automatic test_strobe_lock();
        int pulses = 0, since = 0;
        offset_i = 3'd1; mask_i = '0; mask_update_i = 1'b1;
        for (int i = 0; i < 48; i++) begin
            bit ph;
            ph = (m_pos == 0);
            rand_data(0);
            tick(ph);
            if (ph) begin pulses++; since = 0; end else since++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL strobe_model: got %h want %h", obs_vec(), exp_vec());
            else n_pass++;
            n_checks++;
            if (trig_valid_o !== (pulses >= 1 && (since == 1 || since == 5)))
                $display("FAIL strobe_position: pos %0d valid %b", since, trig_valid_o);
            else n_pass++;
            if (pulses >= 1 && (since == 1 || since == 5)) begin
                n_checks++;
                if (trig_word_o !== ((since == 5) ? 1'b1 : 1'b0))
                    $display("FAIL strobe_word: pos %0d got %0d", since, trig_word_o);
                else n_pass++;
            end
            n_checks++;
            if (locked_o !== (pulses >= 4)) $display("FAIL lock_after_4: pulses %0d locked %b", pulses, locked_o);
            else n_pass++;
        end
    endtask

    task automatic test_mask_update();
        bit upd_done = 0, seen0 = 0, chk1 = 0, chk5 = 0;
        mask_i = '0; mask_i[7] = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bit ph; int p;
            ph = (m_pos == 0); p = ph ? 0 : m_pos;
            rand_data(0);
            trig_dat_i[8*DW +: DW] = 16'hA5A5;
            if (p == 3 && !upd_done) begin mask_update_i = 1'b1; upd_done = 1; end
            else if (upd_done && p == 0) seen0 = 1;
            tick(ph);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL mask_model: got %h want %h", obs_vec(), exp_vec());
            else n_pass++;
            if (upd_done && !seen0 && p == 5 && !chk5) begin
                chk5 = 1; n_checks++;
                if (trig_dat_o[7*DW +: DW] !== 16'hA5A5) $display("FAIL mask_pending: got %h want a5a5", trig_dat_o[7*DW +: DW]);
                else n_pass++;
            end
            if (seen0 && p == 1 && !chk1) begin
                chk1 = 1; n_checks++;
                if (trig_dat_o[7*DW +: DW] !== 16'h0) $display("FAIL mask_applied: got %h want 0000", trig_dat_o[7*DW +: DW]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_compaction();
        for (int i = 0; i < 16; i++) begin
            bit ph, found; int p;
            ph = (m_pos == 0); p = ph ? 0 : m_pos;
            rand_data(1);
            trig_dat_i[23*DW +: DW] = 16'hFFFF;
            trig_dat_i[22*DW +: DW] = 16'h1234;
            tick(ph);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL compact_model: got %h want %h", obs_vec(), exp_vec());
            else n_pass++;
            if (p == 1 || p == 5) begin
                n_checks++;
                if (trig_dat_o[20*DW +: DW] !== 16'h1234) $display("FAIL compact_word20: got %h want 1234", trig_dat_o[20*DW +: DW]);
                else n_pass++;
                found = 0;
                for (int r = 0; r < NREAL; r++) if (trig_dat_o[r*DW +: DW] === 16'hFFFF) found = 1;
                n_checks++;
                if (found) $display("FAIL compact_no_slot7: got ffff present want absent");
                else n_pass++;
            end
        end
    endtask

    task automatic test_phase_err();
        int good = 0;
        for (int i = 0; i < 8 && m_pos != 5; i++) begin rand_data(0); tick(m_pos == 0); end
        n_checks++;
        if (locked_o !== 1'b1) $display("FAIL pre_inject_lock: got %b want 1", locked_o);
        else n_pass++;
        tick(1);
        n_checks++;
        if (phase_err_o !== 1'b1 || locked_o !== 1'b0)
            $display("FAIL phase_inject: perr %b locked %b want 1 0", phase_err_o, locked_o);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            bit ph;
            ph = (m_pos == 0);
            rand_data(0);
            tick(ph);
            if (ph) good++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL phase_model: got %h want %h", obs_vec(), exp_vec());
            else n_pass++;
            n_checks++;
            if (locked_o !== (good >= 4) || phase_err_o !== 1'b1)
                $display("FAIL relock: good %0d locked %b perr %b", good, locked_o, phase_err_o);
            else n_pass++;
        end
    endtask

    task automatic test_align_err();
        offset_i = 3'd1; trig_dat_valid_i = '0;
        for (int i = 0; i < 8 && m_pos != 0; i++) tick(0);
        err_clr_i = 1'b1;
        tick(1);                              // position 0
        n_checks++;
        if (phase_err_o !== 1'b0 || align_err_o !== '0 || align_err_count_o !== 16'd0)
            $display("FAIL err_clear: perr %b align %h cnt %0d want 0", phase_err_o, align_err_o, align_err_count_o);
        else n_pass++;
        trig_dat_valid_i[3] = 1'b1; tick(0);  // position 1 is a strobe: no error
        n_checks++;
        if (align_err_count_o !== 16'd0) $display("FAIL align_on_strobe: cnt %0d want 0", align_err_count_o);
        else n_pass++;
        trig_dat_valid_i = '0; tick(0);
        trig_dat_valid_i[3] = 1'b1; tick(0);  // position 3
        n_checks++;
        if (align_err_o !== 28'h8 || align_err_count_o !== 16'd1)
            $display("FAIL align_pos3: align %h cnt %0d want 0000008 1", align_err_o, align_err_count_o);
        else n_pass++;
        trig_dat_valid_i = '0; trig_dat_valid_i[8] = 1'b1; tick(0);  // masked SURF7
        n_checks++;
        if (align_err_o !== 28'h8 || align_err_count_o !== 16'd1)
            $display("FAIL align_masked: align %h cnt %0d want 0000008 1", align_err_o, align_err_count_o);
        else n_pass++;
        trig_dat_valid_i = '0;
        for (int i = 0; i < 8 && m_pos != 3; i++) tick(m_pos == 0);
        trig_dat_valid_i[3] = 1'b1; err_clr_i = 1'b1; tick(0);
        n_checks++;
        if (align_err_o !== 28'h8 || align_err_count_o !== 16'd1)
            $display("FAIL clr_vs_err: align %h cnt %0d want 0000008 1", align_err_o, align_err_count_o);
        else n_pass++;
        trig_dat_valid_i = '0;
    endtask

    task automatic test_saturation();
        err_clr_i = 1'b1;
        trig_dat_valid_i = '0; trig_dat_valid_i[3] = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            bit ph; int p;
            ph = (m_pos == 0); p = ph ? 0 : m_pos;
            offset_i = 3'((p + 1) % CL);      // keep strobes off the current position
            tick(ph);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL sat_model: cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (align_err_count_o !== 16'hFFFF) $display("FAIL count_saturate: got %h want ffff", align_err_count_o);
        else n_pass++;
        trig_dat_valid_i = '0; offset_i = 3'd1;
    endtask

    task automatic test_reset_mid();
        int nval = 0;
        for (int i = 0; i < 8 && m_pos != 3; i++) tick(m_pos == 0);
        sysclk_rstn_i = 1'b0;
        tick(0);
        n_checks++;
        if (obs_vec() !== '0) $display("FAIL reset_mid: got %h want 0", obs_vec());
        else n_pass++;
        sysclk_rstn_i = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rand_data(0);
            tick(m_pos == 0);
            if (trig_valid_o === 1'b1) begin
                nval++;
                n_checks++;
                if (trig_dat_o !== '0) $display("FAIL reset_mask_ones: got %h want 0", trig_dat_o);
                else n_pass++;
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (nval != 6) $display("FAIL reset_strobe_count: got %0d want 6", nval);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_strobe_lock();
        test_mask_update();
        test_compaction();
        test_phase_err();
        test_align_err();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trig_surf_align.md
Name: trig_surf_align

Overview:
Parametrised front end for the SURF trigger links. It qualifies raw per-slot trigger words against the 8-clock command phase. The valid offset is programmable at runtime rather than fixed by delay lines, and the number of trigger words per command cycle is a parameter. It compacts the populated SURF slots of each TURFIO, applies a glitch-free trigger mask, and tracks phase lock and link misalignment. It sits between the TURFIO trigger inputs and the master trigger processor, and supplies the TURF trigger-issue enable.

Parameters:
NTIO, 4, number of TURFIO groups
SLOTS_PER_TIO, 8, physical slots per TURFIO on the input bus
REAL_PER_TIO, 7, populated slots per TURFIO (slots 0..REAL_PER_TIO-1); must be <= SLOTS_PER_TIO
DW, 16, trigger word width
CYCLE_LEN, 8, command cycle length in clocks; power of 2
WORDS_PER_CYCLE, 2, trigger words per command cycle; power of 2 that divides CYCLE_LEN
LOCK_CYCLES, 4, consecutive good phase pulses required for lock
(derived) NREAL = NTIO*REAL_PER_TIO; PW = log2(CYCLE_LEN); STEP = CYCLE_LEN/WORDS_PER_CYCLE

Ports:
sysclk_i  in  1  system clock; the only clock
sysclk_rstn_i  in  1  reset, synchronous, active-low
sysclk_phase_i  in  1  command-cycle marker, nominally one clock in every CYCLE_LEN
offset_i  in  PW  position of trigger word 0 within the cycle (quasi-static)
mask_i  in  NREAL  trigger mask, 1 = masked
mask_update_i  in  1  pulse that captures mask_i
err_clr_i  in  1  pulse that clears the sticky errors and the error count
trig_dat_i  in  NTIO*SLOTS_PER_TIO*DW  raw trigger words, slot-major within each TURFIO
trig_dat_valid_i  in  NTIO*SLOTS_PER_TIO  per-slot valid flags from the links
trig_dat_o  out  NREAL*DW  compacted, masked trigger words
trig_valid_o  out  1  one-clock pulse marking trig_dat_o as valid
trig_word_o  out  max(1,log2(WORDS_PER_CYCLE))  index of the current word within the cycle
turf_trigger_ce_o  out  1  TURF trigger-issue enable; coincides with trig_valid_o
locked_o  out  1  phase locked
phase_err_o  out  1  sticky phase error
align_err_o  out  NREAL  sticky per-SURF misalignment flags
align_err_count_o  out  16  saturating count of misaligned cycles

Behaviour:
- Reset (sysclk_rstn_i = 0 at a clock edge):
  - Registers cleared: all outputs 0, sync = 0, lock counter = 0, position counter = 0.
  - Active mask and shadow mask are set to all ones.
  - Reset takes effect mid-cycle, with no partial output afterwards.
- Position tracking:
  - The cycle in which sysclk_phase_i = 1 is position 0; position increments mod CYCLE_LEN.
  - The first sysclk_phase_i after reset sets sync = 1. Position then free-runs and realigns to every sysclk_phase_i.
- Phase errors:
  - sysclk_phase_i at a position other than 0, or absent at position 0 while sync = 1, is a phase error.
  - On a phase error: phase_err_o is set (sticky), locked_o drops and the lock counter is cleared.
  - Each sysclk_phase_i arriving at position 0 increments the lock counter, saturating. locked_o = 1 once the counter reaches LOCK_CYCLES.
- Strobe generation:
  - Requires sync = 1.
  - The strobe fires at positions (offset_i + k*STEP) mod CYCLE_LEN, for k = 0..WORDS_PER_CYCLE-1, with word index k.
- Data path:
  - On a strobe cycle, trig_dat_i is sampled.
  - Real SURF r = t*REAL_PER_TIO + s maps from slot (t, s); unpopulated slots are ignored.
  - A masked SURF's word is output as 0.
  - Latency is one clock: trig_dat_o, trig_valid_o, trig_word_o and turf_trigger_ce_o are all registered.
  - trig_dat_o holds its value between strobes.
- Mask update:
  - mask_update_i latches mask_i into the shadow mask.
  - The shadow mask becomes the active mask at the next position-0 cycle. If the update coincides with position 0, the new mask applies in that same cycle.
  - No mask change takes effect mid-cycle.
- Misalignment:
  - Condition: sync = 1, not a strobe cycle, unmasked populated slot with its valid flag = 1.
  - Effect: the corresponding align_err_o bit is set. align_err_count_o increments by 1 per such cycle, regardless of how many SURFs are involved, and saturates at 0xFFFF.
- err_clr_i:
  - Clears phase_err_o, align_err_o and align_err_count_o.
  - A new error in the same cycle wins: the bit stays set and the count becomes 1.
- offset_i changes take effect on the next clock; the spec guarantees no output correctness during the change.

Decomposition:
- Package trig_align_pkg: CYCLE_LEN default, LOCK_CYCLES default, count width 16, and a function real_index(t, s, REAL_PER_TIO).
- Sub-module trig_phase_tracker: position counter, sync/lock/phase-error logic, strobe and word-index generation.
- The top level holds the data path, the mask registers and the error logic.

Test Plan:
- Defaults, offset_i = 1, sysclk_phase_i every 8 clocks -> trig_valid_o at positions 2 and 6, trig_word_o = 0 then 1; locked_o = 1 after the 4th phase pulse.
- TIO1 slot0 = 0xA5A5, mask_i bit7 = 1, mask_update_i at position 3 -> trig_dat_o word7 = 0xA5A5 through that cycle, then 0x0000 from the first strobe after position 0.
- TIO2 slot7 = 0xFFFF and TIO2 slot6 = 0x1234 (unmasked) -> word20 = 0x1234; 0xFFFF never appears on trig_dat_o.
- sysclk_phase_i injected at position 5 -> phase_err_o = 1 and locked_o = 0 next clock, positions realign; locked_o = 1 again after 4 good pulses.
- offset_i = 1, trig_dat_valid_i for SURF3 (TIO0 slot3) high at position 3 -> align_err_o[3] = 1, count = 1; err_clr_i coincident with a repeat error -> bit remains 1, count = 1.
- 70000 misaligned cycles -> count = 0xFFFF; sysclk_rstn_i low mid-cycle -> all outputs 0 at the next edge, active mask all ones.
